vpu_dst_wr_buf: RTL and testbench

//  Destination write stage directly downstream of the FP ALU (max/avg) result path.

---
 rtl/vpu_dst_wr_buf_if.sv | 28 ++
 rtl/vpu_dst_wr_buf.sv | 130 +++++++++++++
 tb/tb_vpu_dst_wr_buf.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vpu_dst_wr_buf_if.sv
// Bus bundle for the destination write stage.
//   result_*   : ALU result stream, valid/ready handshake (ALU -> stage)
//   sram_wr_*  : SRAM write port, request/grant handshake (stage -> SRAM)
// Signal names keep the _i/_o suffixes as seen from the write stage.
//   slave  : write-stage view
//   master : view of the surrounding logic (ALU + SRAM port model)
interface vpu_dst_wr_buf_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic [DATA_W-1:0] result_i;
    logic              result_valid_i;
    logic              result_ready_o;
    logic              sram_wr_en_o;
    logic [ADDR_W-1:0] sram_wr_addr_o;
    logic [DATA_W-1:0] sram_wr_data_o;
    logic              sram_wr_gnt_i;

    modport slave (
        input  result_i, result_valid_i, sram_wr_gnt_i,
        output result_ready_o, sram_wr_en_o, sram_wr_addr_o, sram_wr_data_o
    );

    modport master (
        output result_i, result_valid_i, sram_wr_gnt_i,
        input  result_ready_o, sram_wr_en_o, sram_wr_addr_o, sram_wr_data_o
    );
endinterface

// File: rtl/vpu_dst_wr_buf.sv
// Destination write stage behind the FP ALU result path.
// Buffers ALU results in a small FIFO and writes them to consecutive SRAM
// word addresses starting at a programmed base, decoupling ALU issue from
// SRAM grant stalls.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start_i        one-cycle job start (honoured in IDLE only)
//   base_addr_i    first SRAM word address, sampled with start_i
//   len_i          results in job (0 .. 2^ADDR_W), sampled with start_i
//   bus            result stream + SRAM write port (slave modport)
//   busy_o         job in progress (state != IDLE)
//   done_o         one-cycle pulse after the last result is written
module vpu_dst_wr_buf #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    vpu_dst_wr_buf_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W:0]   len_q, acc_cnt, wr_cnt;
    logic [ADDR_W:0]   acc_nxt, wr_nxt;
    logic [ADDR_W-1:0] addr_q;

    logic fifo_full, fifo_empty;
    logic rdy, wr_en, push, pop, start_ok;

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);

    // Ready ignores the grant so a full FIFO never takes a beat on a pop cycle.
    assign rdy      = (state == ST_RUN) & ~fifo_full & (acc_cnt < len_q);
    assign wr_en    = ((state == ST_RUN) | (state == ST_DRAIN)) & ~fifo_empty;
    assign push     = bus.result_valid_i & rdy;
    assign pop      = wr_en & bus.sram_wr_gnt_i;
    assign start_ok = (state == ST_IDLE) & start_i;

    assign acc_nxt = acc_cnt + (ADDR_W+1)'(push);
    assign wr_nxt  = wr_cnt + (ADDR_W+1)'(pop);

    assign bus.result_ready_o = rdy;
    assign bus.sram_wr_en_o   = wr_en;
    assign bus.sram_wr_addr_o = addr_q;
    // Head is masked while idle so stale entries left by a reset never show.
    assign bus.sram_wr_data_o = wr_en ? mem[rd_ptr] : '0;

    assign busy_o = (state != ST_IDLE);
    assign done_o = (state == ST_DONE);

    // Transitions look at next-cycle counter values so DONE follows the
    // final grant (or final accept) by exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_i) state_nxt = (len_i == '0) ? ST_DONE : ST_RUN;
            ST_RUN: begin
                if (wr_nxt == len_q)       state_nxt = ST_DONE;
                else if (acc_nxt == len_q) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (wr_nxt == len_q) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            acc_cnt <= '0;
            wr_cnt  <= '0;
            addr_q  <= '0;
        end else if (start_ok) begin
            len_q   <= len_i;
            acc_cnt <= '0;
            wr_cnt  <= '0;
            addr_q  <= base_addr_i;
        end else begin
            acc_cnt <= acc_nxt;
            wr_cnt  <= wr_nxt;
            if (pop) addr_q <= addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.result_i;
    end
endmodule

// File: tb/tb_vpu_dst_wr_buf.sv
module tb_vpu_dst_wr_buf;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;
    localparam int ASPACE = 1 << ADDR_W;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [ADDR_W:0]   len_i;
    logic              busy_o, done_o;

    vpu_dst_wr_buf_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    vpu_dst_wr_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: a job is described by base, len and how many results
    // have been accepted / written since it started. Everything expected
    // follows from those numbers.
    exp_t sb[$];
    int   tot_acc = 0, tot_wr = 0;
    int   job_acc0 = 0, job_wr0 = 0;
    int   m_base = 0, m_len = 0;
    logic job = 1'b0;

    int vp = 0, gp = 0;

    // Model / stimulus observer: expected writes are queued as beats are accepted.
    always @(negedge clk) begin
        if (!rst_n) begin
            job <= 1'b0;
            sb.delete();
        end else begin
            chk("busy", 32'(busy_o), 32'(job));
            chk("done", 32'(done_o), 32'(job && (tot_wr - job_wr0) == m_len));
            chk("ready", 32'(bus.result_ready_o),
                32'(job && (tot_acc - job_acc0) < m_len &&
                    ((tot_acc - job_acc0) - (tot_wr - job_wr0)) < DEPTH));
            chk("wr_en", 32'(bus.sram_wr_en_o),
                32'(job && (tot_acc - job_acc0) > (tot_wr - job_wr0)));
            if (bus.result_valid_i && bus.result_ready_o) begin
                sb.push_back('{ADDR_W'((m_base + (tot_acc - job_acc0)) % ASPACE), bus.result_i});
                tot_acc <= tot_acc + 1;
            end
            if (job && (tot_wr - job_wr0) == m_len) begin
                job <= 1'b0;
            end else if (!job && start_i) begin
                job      <= 1'b1;
                m_base   <= int'(base_addr_i);
                m_len    <= int'(len_i);
                job_acc0 <= tot_acc;
                job_wr0  <= tot_wr;
            end
        end
    end

    // Monitor: pops and compares on every granted write.
    logic              stall = 1'b0;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall <= 1'b0;
        end else begin
            if (stall) begin
                chk("hold_en", 32'(bus.sram_wr_en_o), 32'd1);
                chk("hold_addr", 32'(bus.sram_wr_addr_o), 32'(hold_addr));
                chk("hold_data", 32'(bus.sram_wr_data_o), 32'(hold_data));
            end
            if (bus.sram_wr_en_o && bus.sram_wr_gnt_i) begin
                if (sb.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    chk("wr_addr", 32'(bus.sram_wr_addr_o), 32'(sb[0].addr));
                    chk("wr_data", 32'(bus.sram_wr_data_o), 32'(sb[0].data));
                    void'(sb.pop_front());
                end
                tot_wr <= tot_wr + 1;
            end
            stall     <= bus.sram_wr_en_o && !bus.sram_wr_gnt_i;
            hold_addr <= bus.sram_wr_addr_o;
            hold_data <= bus.sram_wr_data_o;
        end
    end

    // Random ALU / SRAM port behaviour, steered by vp/gp percentages.
    initial begin
        bus.result_i       = '0;
        bus.result_valid_i = 1'b0;
        bus.sram_wr_gnt_i  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.result_valid_i = ($urandom_range(99) < vp);
            bus.result_i       = DATA_W'($urandom);
            bus.sram_wr_gnt_i  = ($urandom_range(99) < gp);
        end
    end

    task automatic start_job(input int b, input int l);
        @(posedge clk);
        #1;
        start_i     = 1'b1;
        base_addr_i = ADDR_W'(b);
        len_i       = (ADDR_W+1)'(l);
        @(posedge clk);
        #1;
        start_i     = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (job && n < max_cyc);
        if (job) fail({name, "_timeout"});
    endtask

    function automatic int job_acc();
        return tot_acc - job_acc0;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n       = 1'b0;
        start_i     = 1'b0;
        base_addr_i = '0;
        len_i       = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready", 32'(bus.result_ready_o), 32'd0);
        chk("rst_en",    32'(bus.sram_wr_en_o),   32'd0);
        chk("rst_addr",  32'(bus.sram_wr_addr_o), 32'd0);
        chk("rst_data",  32'(bus.sram_wr_data_o), 32'd0);
        chk("rst_busy",  32'(busy_o),             32'd0);
        chk("rst_done",  32'(done_o),             32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Streaming at full rate.
        vp = 100; gp = 100;
        start_job(12'h010, 8);
        wait_idle("t2", 100);

        // Grant withheld: FIFO fills to depth, write request held stable.
        vp = 100; gp = 0;
        start_job(12'h020, 6);
        repeat (10) @(negedge clk);
        #1;
        chk("t3_accepted", 32'(job_acc()), 32'd4);
        gp = 100;
        wait_idle("t3", 100);

        // Address wrap at the top of the SRAM.
        vp = 70; gp = 70;
        start_job(12'h3FE, 4);
        wait_idle("t4", 200);

        // Empty job, then a start pulse during RUN that must be ignored.
        start_job(12'h055, 0);
        wait_idle("t5a", 20);
        vp = 60; gp = 50;
        start_job(12'h100, 5);
        repeat (2) @(posedge clk);
        #1;
        start_i = 1'b1; base_addr_i = 10'h200; len_i = 11'd2;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_idle("t5b", 300);

        // Over-supply: only len results taken.
        vp = 100; gp = 0;
        start_job(12'h030, 3);
        repeat (6) @(negedge clk);
        #1;
        chk("t6_accepted", 32'(job_acc()), 32'd3);
        gp = 100;
        wait_idle("t6", 100);

        // Reset mid-job with entries buffered.
        vp = 100; gp = 0;
        start_job(12'h040, 8);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_ready", 32'(bus.result_ready_o), 32'd0);
        chk("t1_en",    32'(bus.sram_wr_en_o),   32'd0);
        chk("t1_addr",  32'(bus.sram_wr_addr_o), 32'd0);
        chk("t1_data",  32'(bus.sram_wr_data_o), 32'd0);
        chk("t1_busy",  32'(busy_o),             32'd0);
        chk("t1_done",  32'(done_o),             32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        gp = 100;
        repeat (6) @(negedge clk);

        // Randomised jobs.
        for (int j = 0; j < 30; j++) begin
            vp = $urandom_range(100, 30);
            gp = $urandom_range(100, 30);
            start_job($urandom_range(ASPACE - 1), ($urandom_range(9) == 0) ? 0 : $urandom_range(20, 1));
            wait_idle("rand", 1000);
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
